// File: rtl/spi_pkg.sv
// Shared SPI datapath definitions: receive FSM states and counter sizing helper.
package spi_pkg;

  typedef enum logic [0:0] {
    RX_IDLE = 1'b0,
    RX_RECV = 1'b1
  } rx_state_t;

  // Counter width able to hold 0..width-1; never narrower than one bit.
  function automatic int cnt_w(input int width);
    if (width > 2) begin
      return $clog2(width);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/spi_rx_holdreg.sv
// Single-entry valid/ready holding register with a load port and a dropped-word pulse.
module spi_rx_holdreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_r;
  logic             valid_r;
  logic             overrun_r;
  logic             accept_s;
  logic             drain_s;

  // A new word may take the slot when it is empty or emptying this cycle.
  always_comb begin
    drain_s  = valid_r && ready;
    accept_s = load && (!valid_r || ready);
  end

  // Holding slot and overrun pulse; a load wins over a same-cycle drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r    <= {WIDTH{1'b0}};
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= load && !accept_s;
      if (accept_s) begin
        data_r  <= load_data;
        valid_r <= 1'b1;
      end else if (drain_s) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign data    = data_r;
  assign valid   = valid_r;
  assign overrun = overrun_r;

endmodule

// File: rtl/spi_deserializer.sv
// SPI receive stage: frame-gated bit sampling into WIDTH-bit words, handed off
// through a single-entry holding register.
module spi_deserializer
  import spi_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             frame_active,
  input  logic             i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_overrun,
  output logic             o_busy
);

  localparam int               CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  rx_state_t        state_r;
  rx_state_t        state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shift_next_s;
  logic             sample_s;
  logic             clear_s;
  logic             complete_s;

  // Receive FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RX_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state and per-cycle sample/clear decisions; frame end discards the partial word.
  always_comb begin
    state_next_s = state_r;
    sample_s     = 1'b0;
    clear_s      = 1'b0;
    case (state_r)
      RX_IDLE: begin
        if (frame_active) begin
          state_next_s = RX_RECV;
        end else begin
          state_next_s = RX_IDLE;
        end
      end
      RX_RECV: begin
        if (!frame_active) begin
          state_next_s = RX_IDLE;
          clear_s      = 1'b1;
        end else begin
          state_next_s = RX_RECV;
          sample_s     = enable;
        end
      end
      default: begin
        state_next_s = RX_IDLE;
        clear_s      = 1'b1;
      end
    endcase
  end

  // Shift direction decides where the first received bit ends up.
  always_comb begin
    if (MSB_FIRST) begin
      shift_next_s = {shift_r[WIDTH-2:0], i_data};
    end else begin
      shift_next_s = {i_data, shift_r[WIDTH-1:1]};
    end
    complete_s = sample_s && (cnt_r == LAST);
  end

  // Bit counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {CNT_W{1'b0}};
      shift_r <= {WIDTH{1'b0}};
    end else if (clear_s) begin
      cnt_r   <= {CNT_W{1'b0}};
      shift_r <= {WIDTH{1'b0}};
    end else if (sample_s) begin
      shift_r <= shift_next_s;
      if (complete_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  spi_rx_holdreg #(
    .WIDTH(WIDTH)
  ) u_holdreg (
    .clk      (clk),
    .rst      (rst),
    .load     (complete_s),
    .load_data(shift_next_s),
    .ready    (i_ready),
    .data     (o_data),
    .valid    (o_valid),
    .overrun  (o_overrun)
  );

  assign o_busy = (cnt_r != {CNT_W{1'b0}});

endmodule

// File: doc/spi_deserializer.md
# spi_deserializer

Serial-to-parallel receive stage of the SPI datapath: samples one bit per `enable` strobe while a frame is active, assembles `WIDTH`-bit words and hands each completed word downstream through a valid/ready holding register. It is the receive-side counterpart of the transmit serializer and consumes the serial line (MISO on master, MOSI on slave). Partial words are discarded on frame end, and words arriving while the holding register is still occupied are reported as overruns.

## Interface
- `WIDTH`, 8: word length in bits; must be ≥ 2.
- `MSB_FIRST`, 1: 1 means the first sampled bit lands in `o_data[WIDTH-1]`; 0 means it lands in `o_data[0]`.

- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  sample strobe, one cycle per serial bit (from the SCK edge detector).
- `frame_active`  in  1  high for the duration of a frame (CS asserted).
- `i_data`  in  1  serial input bit, sampled when `enable && frame_active`.
- `o_data`  out  WIDTH  received word; stable while `o_valid` is high.
- `o_valid`  out  1  holding register contains an undelivered word.
- `i_ready`  in  1  downstream accepts the word when `o_valid && i_ready`.
- `o_overrun`  out  1  one-cycle pulse when a completed word is dropped.
- `o_busy`  out  1  high when a partial word is pending (bit count ≠ 0).

## Operation
- Receive FSM has two states, IDLE and RECV.
  - IDLE → RECV on `frame_active`.
  - RECV → IDLE on `!frame_active`. This clears the shift register and bit counter, and the partial word is discarded silently.
- In RECV, each cycle with `enable` high shifts `i_data` into the shift register and increments the bit counter.
  - MSB_FIRST=1: shift left, new bit enters at the LSB.
  - MSB_FIRST=0: shift right, new bit enters at the MSB.
- When the counter reaches `WIDTH-1` and `enable` is high, the word completes. The counter wraps to 0 and the completed word, including the current bit, is offered to the holding register.
- Holding register accepts a completed word if it is empty, or if it is being drained in the same cycle (`o_valid && i_ready`).
  - On accept: load `o_data`, set `o_valid`.
  - Otherwise: drop the new word, keep the old `o_data`/`o_valid`, and pulse `o_overrun`.
- `o_valid` clears on `o_valid && i_ready` unless a new word loads in the same cycle.
- `enable` while `!frame_active` is ignored. `frame_active` and `enable` are both evaluated in the same cycle: a bit is sampled only if both are high.
- `o_busy` = (bit counter ≠ 0).
- The holding register is independent of frame state. A delivered word survives a frame end.

## Timing
- Reset values: `o_data`=0, `o_valid`=0, `o_overrun`=0, `o_busy`=0, FSM=IDLE, counter=0, shift register=0.
- `rst` overrides everything, including a same-cycle completion or handshake.
- Latency: `o_valid` rises on the clock edge following the cycle in which the `WIDTH`-th `enable` is sampled.
- Back-to-back words need no gap. Minimum spacing is `WIDTH` `enable` strobes, and `enable` may be high every cycle.
- Throughput is one word per `WIDTH` strobes when `i_ready` is held high.
- `o_overrun` is registered and asserts one cycle after the dropped completion, coincident with the edge where the load would have occurred.
- `frame_active` falling in the completing cycle: the bit is not sampled, the word is discarded, and no `o_valid` is produced.

## Structure
- Shared package `spi_pkg`:
  - `CNT_W = $clog2(WIDTH)` helper function.
  - FSM state typedef `rx_state_t {RX_IDLE, RX_RECV}`.
- Sub-module `spi_rx_holdreg`: a single-entry valid/ready buffer with a load port, an overrun pulse output and a WIDTH parameter. It is reusable by the transmit path.
- Top level contains the FSM, bit counter and shift register. Target size is roughly 150–250 lines total.

## Test plan
- Reset, then frame with 8 strobes of bits 1,0,1,0,0,1,0,1, `i_ready`=1, MSB_FIRST=1 → `o_data`=0xA5 and `o_valid` high for exactly 1 cycle, one cycle after the 8th strobe.
- Same bits with MSB_FIRST=0 → `o_data`=0xA5 bit-reversed, i.e. 0xA5 (palindrome). Then send 0x01's bits (0,0,0,0,0,0,0,1) → `o_data`=0x80.
- `i_ready`=0, two consecutive words 0x3C then 0xC3 → `o_data` stays 0x3C, `o_valid` stays high, one `o_overrun` pulse. Raise `i_ready` → 0x3C is delivered and `o_valid` drops.
- Drain and load in the same cycle: `i_ready` rises exactly in the completion cycle of word 0x55 while 0x3C is held → 0x3C is handshaked, 0x55 loads, `o_valid` stays high, and no overrun occurs.
- `frame_active` drops after 5 strobes, then a new frame sends 0xF0 → no `o_valid` for the partial word, `o_busy` falls with the frame, and the next output is exactly 0xF0.
- `rst` asserted mid-word (after 3 strobes) and while `o_valid`=1 → all outputs return to reset values next cycle. The next full frame yields the correct word.
